// File: rtl/ring_tune_pkg.sv
// rtl/ring_tune_pkg.sv - shared types and sizing helpers for the ring tuning controller
package ring_tune_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SWEEP   = 3'd1,
    ST_TRACK_C = 3'd2,
    ST_TRACK_P = 3'd3,
    ST_TRACK_M = 3'd4,
    ST_FAULT   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    PROBE_C = 2'd0,
    PROBE_P = 2'd1,
    PROBE_M = 2'd2
  } probe_t;

  function automatic int code_max(input int code_w);
    return (1 << code_w) - 1;
  endfunction

  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pdm_modulator.sv
// rtl/pdm_modulator.sv - first-order PDM of the heater code, one bit per clock
module pdm_modulator #(
  parameter int CODE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] code,
  output logic              pdm
);

  logic [CODE_W:0] acc_q;
  logic [CODE_W:0] acc_d;

  assign acc_d = {1'b0, acc_q[CODE_W-1:0]} + {1'b0, code};

  // Accumulate the code; the top bit holds the carry of the last add.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign pdm = acc_q[CODE_W];

endmodule

// File: rtl/ring_tuning_controller.sv
// rtl/ring_tuning_controller.sv - sweep-then-hill-climb thermal tuner for one ring resonator
module ring_tuning_controller
  import ring_tune_pkg::*;
#(
  parameter int CODE_W      = 8,
  parameter int ADC_W       = 10,
  parameter int SETTLE_CYC  = 16,
  parameter int LOCK_ROUNDS = 4,
  parameter int INIT_CODE   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              start,
  input  logic [ADC_W-1:0]  pd_data,
  input  logic              pd_valid,
  output logic [CODE_W-1:0] heater_code,
  output logic              heater_pdm,
  output logic [2:0]        state_o,
  output logic              busy,
  output logic              locked,
  output logic              fault
);

  localparam int SET_W = cnt_w(SETTLE_CYC);
  localparam int STB_W = cnt_w(LOCK_ROUNDS);
  localparam logic [CODE_W-1:0] CODE_TOP    = CODE_W'(code_max(CODE_W));
  localparam logic [CODE_W-1:0] CODE_INIT   = CODE_W'(INIT_CODE);
  localparam logic [SET_W-1:0]  SETTLE_LOAD = SET_W'(SETTLE_CYC);
  localparam logic [STB_W-1:0]  STABLE_SAT  = STB_W'(LOCK_ROUNDS);

  state_t             state_q, state_d;
  logic [CODE_W-1:0]  code_q, code_d, center_q, center_d, best_code_q, best_code_d;
  logic [ADC_W-1:0]   best_pwr_q, best_pwr_d, p0_q, p0_d, pp_q, pp_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [STB_W-1:0]   stable_q, stable_d;
  logic               locked_q, locked_d;
  logic               meas, load, round_done;
  probe_t             res_sel;
  logic [CODE_W-1:0]  res_code;
  logic [ADC_W-1:0]   res_pwr, pp_pwr;

  // A sample counts only once the heater has settled at the current code.
  assign meas = pd_valid && (settle_q == '0);

  // Lowest-power probe of the round wins; ties keep centre, then the +1 probe.
  always_comb begin
    pp_pwr  = (state_q == ST_TRACK_P) ? pd_data : pp_q;
    res_sel = PROBE_C;
    res_pwr = p0_q;
    if (center_q != CODE_TOP && pp_pwr < res_pwr) begin
      res_sel = PROBE_P;
      res_pwr = pp_pwr;
    end
    if (state_q == ST_TRACK_M && pd_data < res_pwr) begin
      res_sel = PROBE_M;
      res_pwr = pd_data;
    end
    case (res_sel)
      PROBE_P: res_code = center_q + 1'b1;
      PROBE_M: res_code = center_q - 1'b1;
      default: res_code = center_q;
    endcase
  end

  // Next-state, heater code and bookkeeping for sweep and track rounds.
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    center_d    = center_q;
    best_code_d = best_code_q;
    best_pwr_d  = best_pwr_q;
    p0_d        = p0_q;
    pp_d        = pp_q;
    stable_d    = stable_q;
    locked_d    = locked_q;
    load        = 1'b0;
    round_done  = 1'b0;
    settle_d    = (settle_q == '0) ? '0 : settle_q - 1'b1;

    case (state_q)
      ST_IDLE, ST_FAULT: begin
        if (start) begin
          state_d     = ST_SWEEP;
          code_d      = '0;
          best_pwr_d  = '1;
          best_code_d = '0;
          stable_d    = '0;
          locked_d    = 1'b0;
          load        = 1'b1;
        end
      end
      ST_SWEEP: begin
        if (meas) begin
          if (pd_data < best_pwr_q) begin
            best_pwr_d  = pd_data;
            best_code_d = code_q;
          end
          if (code_q == CODE_TOP) begin
            state_d  = ST_TRACK_C;
            code_d   = best_code_d;
            center_d = best_code_d;
          end else begin
            code_d = code_q + 1'b1;
          end
          load = 1'b1;
        end
      end
      ST_TRACK_C: begin
        if (meas) begin
          p0_d = pd_data;
          load = 1'b1;
          if (center_q != CODE_TOP) begin
            state_d = ST_TRACK_P;
            code_d  = center_q + 1'b1;
          end else begin
            state_d = ST_TRACK_M;
            code_d  = center_q - 1'b1;
          end
        end
      end
      ST_TRACK_P: begin
        if (meas) begin
          pp_d = pd_data;
          load = 1'b1;
          if (center_q != '0) begin
            state_d = ST_TRACK_M;
            code_d  = center_q - 1'b1;
          end else begin
            round_done = 1'b1;
          end
        end
      end
      ST_TRACK_M: begin
        if (meas) begin
          load       = 1'b1;
          round_done = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (round_done) begin
      code_d   = res_code;
      center_d = res_code;
      if (res_code == '0 || res_code == CODE_TOP) begin
        state_d  = ST_FAULT;
        stable_d = '0;
        locked_d = 1'b0;
      end else begin
        state_d = ST_TRACK_C;
        if (res_code != center_q) begin
          stable_d = '0;
          locked_d = 1'b0;
        end else begin
          if (stable_q != STABLE_SAT) stable_d = stable_q + 1'b1;
          locked_d = (stable_d == STABLE_SAT);
        end
      end
    end

    if (load) settle_d = SETTLE_LOAD;

    if (!en) begin
      state_d  = ST_IDLE;
      code_d   = CODE_INIT;
      stable_d = '0;
      locked_d = 1'b0;
    end
  end

  // Controller state registers; reset drops every sample-derived value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      code_q      <= CODE_INIT;
      center_q    <= '0;
      best_code_q <= '0;
      best_pwr_q  <= '1;
      p0_q        <= '0;
      pp_q        <= '0;
      settle_q    <= '0;
      stable_q    <= '0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      center_q    <= center_d;
      best_code_q <= best_code_d;
      best_pwr_q  <= best_pwr_d;
      p0_q        <= p0_d;
      pp_q        <= pp_d;
      settle_q    <= settle_d;
      stable_q    <= stable_d;
      locked_q    <= locked_d;
    end
  end

  pdm_modulator #(.CODE_W(CODE_W)) u_pdm (
    .clk   (clk),
    .rst_n (rst_n),
    .code  (code_q),
    .pdm   (heater_pdm)
  );

  assign heater_code = code_q;
  assign state_o     = state_q;
  assign busy        = state_q inside {ST_SWEEP, ST_TRACK_C, ST_TRACK_P, ST_TRACK_M};
  assign fault       = (state_q == ST_FAULT);
  assign locked      = locked_q;

endmodule

// File: tb/tb_ring_tuning_controller.sv
// tb/tb_ring_tuning_controller.sv - bench for ring_tuning_controller with a ring power plant model
module tb_ring_tuning_controller;
  import ring_tune_pkg::*;

  localparam int SETTLE = 16;
  localparam int LOCKR  = 4;
  localparam int TOP    = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       start = 1'b0;
  logic [9:0] pd_data = '0;
  logic       pd_valid = 1'b0;
  logic [7:0] heater_code;
  logic       heater_pdm;
  logic [2:0] state_o;
  logic       busy, locked, fault;

  int errors = 0;
  int checks = 0;
  int dip = 100;
  int hold_code = -1;
  int min_hold = 1000000;
  bit hold_track = 1'b0;
  int   rec_code[$];
  logic rec_locked[$];

  always #5 clk = ~clk;

  ring_tuning_controller dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start),
    .pd_data(pd_data), .pd_valid(pd_valid),
    .heater_code(heater_code), .heater_pdm(heater_pdm), .state_o(state_o),
    .busy(busy), .locked(locked), .fault(fault)
  );

  function automatic int pwr(input int c, input int d);
    int v;
    v = ((c > d) ? c - d : d - c) * 4 + 50;
    return (v > 1023) ? 1023 : v;
  endfunction

  function automatic int sweep_best(input int d);
    int m;
    m = 1023;
    for (int c = 0; c <= TOP; c++) if (pwr(c, d) < m) m = pwr(c, d);
    for (int c = 0; c <= TOP; c++) if (pwr(c, d) == m) return c;
    return 0;
  endfunction

  function automatic int round_next(input int c, input int d);
    int cand[$];
    int best;
    cand.push_back(c);
    if (c < TOP) cand.push_back(c + 1);
    if (c > 0)   cand.push_back(c - 1);
    best = cand[0];
    foreach (cand[i]) if (pwr(cand[i], d) < pwr(best, d)) best = cand[i];
    return best;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int limit, input string tag);
    int n = 0;
    while (state_o !== s && n < limit) begin @(negedge clk); n++; end
    check(tag, state_o, s);
  endtask

  task automatic wait_code(input int c, input int limit, input string tag);
    int n = 0;
    while (int'(heater_code) != c && n < limit) begin @(negedge clk); n++; end
    check(tag, heater_code, c);
  endtask

  task automatic wait_locked(input logic v, input int limit, input string tag);
    int n = 0;
    while (locked !== v && n < limit) begin @(negedge clk); n++; end
    check(tag, locked, v);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_rounds(input int base, input int center, input int d, input int stable0, input string tag);
    int c, st, nx, n;
    logic el;
    c = center; st = stable0; n = 0;
    do begin
      nx = round_next(c, d);
      st = (nx != c) ? 0 : ((st < LOCKR) ? st + 1 : st);
      el = (st == LOCKR) && nx != 0 && nx != TOP;
      if (base + n < rec_code.size()) begin
        check({tag, "_code"}, rec_code[base + n], nx);
        check({tag, "_locked"}, rec_locked[base + n], el);
      end
      n++;
      c = nx;
    end while (!el && nx != 0 && nx != TOP && n < 50);
    check({tag, "_rounds"}, rec_code.size() - base, n);
  endtask

  task automatic count_ones(input int exp, input string tag);
    int ones = 0;
    repeat (256) begin @(negedge clk); ones += int'(heater_pdm); end
    check(tag, ones, exp);
  endtask

  // Ring plant: power follows the current heater code; settling samples carry misleading low values.
  initial begin
    int age;
    logic [7:0] last;
    age = 0; last = 8'd0;
    forever begin
      @(negedge clk);
      if (heater_code !== last) begin
        if (hold_track && state_o == ST_SWEEP && age + 1 < min_hold) min_hold = age + 1;
        age = 0;
        last = heater_code;
      end else begin
        age++;
      end
      if (hold_code == int'(heater_code)) begin
        pd_valid = 1'b0;
      end else if (age < SETTLE) begin
        pd_valid = 1'($urandom_range(0, 1));
        pd_data  = 10'($urandom_range(0, 49));
      end else begin
        pd_valid = 1'($urandom_range(0, 1));
        pd_data  = 10'(pwr(int'(heater_code), dip));
      end
    end
  end

  // Round monitor: log the code and lock flag each time a track round resolves.
  initial begin
    logic [2:0] prev;
    prev = ST_IDLE;
    forever begin
      @(negedge clk);
      if ((prev == ST_TRACK_P || prev == ST_TRACK_M) && (state_o == ST_TRACK_C || state_o == ST_FAULT)) begin
        rec_code.push_back(int'(heater_code));
        rec_locked.push_back(locked);
      end
      prev = state_o;
    end
  end

  initial begin
    int base, k;
    repeat (3) @(negedge clk);
    check("rst_state", state_o, ST_IDLE);
    check("rst_code", heater_code, 0);
    check("rst_pdm", heater_pdm, 0);
    check("rst_busy", busy, 0);
    check("rst_locked", locked, 0);
    check("rst_fault", fault, 0);

    rst_n = 1'b1; en = 1'b1;
    @(negedge clk);
    pulse_start();
    wait_code(37, 2000, "reach_37");
    @(posedge clk); #3 rst_n = 1'b0; #1;
    check("rstmid_state", state_o, ST_IDLE);
    check("rstmid_code", heater_code, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_pdm", heater_pdm, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_state", state_o, ST_IDLE);
    check("post_rst_code", heater_code, 0);

    dip = 100; hold_track = 1'b1; min_hold = 1000000;
    base = rec_code.size();
    pulse_start();
    wait_state(ST_TRACK_C, 12000, "sweep_to_track");
    hold_track = 1'b0;
    check("sweep_best_code", heater_code, sweep_best(100));
    check("sweep_min_hold_ok", min_hold >= SETTLE + 1, 1);
    check("track_busy", busy, 1);
    wait_locked(1'b1, 3000, "lock_at_100");
    #1;
    check_rounds(base, sweep_best(100), 100, 0, "lock100");
    check("lock100_code", heater_code, 100);

    base = rec_code.size();
    dip = 102;
    wait_locked(1'b0, 1000, "unlock_on_shift");
    wait_locked(1'b1, 3000, "lock_at_102");
    #1;
    check_rounds(base, 100, 102, LOCKR, "lock102");
    check("lock102_code", heater_code, 102);

    wait_state(ST_TRACK_P, 1000, "reach_track_p");
    en = 1'b0;
    @(negedge clk);
    check("endrop_state", state_o, ST_IDLE);
    check("endrop_code", heater_code, 0);
    check("endrop_locked", locked, 0);
    check("endrop_busy", busy, 0);
    pulse_start();
    @(negedge clk);
    check("start_en_low_state", state_o, ST_IDLE);

    en = 1'b1; dip = 255;
    @(negedge clk);
    base = rec_code.size();
    pulse_start();
    wait_state(ST_FAULT, 12000, "fault_reached");
    #1;
    check("fault_flag", fault, 1);
    check("fault_code", heater_code, 255);
    check("fault_locked", locked, 0);
    check("fault_busy", busy, 0);
    check_rounds(base, sweep_best(255), 255, 0, "fault_round");
    @(negedge clk);
    pulse_start();
    check("restart_state", state_o, ST_SWEEP);
    check("restart_fault", fault, 0);
    check("restart_code", heater_code, 0);

    hold_code = 64;
    wait_code(64, 4000, "pdm_reach_64");
    repeat (20) @(negedge clk);
    count_ones(64, "pdm_ones_64");
    k = $urandom_range(65, 200);
    hold_code = k;
    wait_code(k, 6000, "pdm_reach_rand");
    repeat (20) @(negedge clk);
    count_ones(k, "pdm_ones_rand");
    en = 1'b0; hold_code = -1;
    repeat (20) @(negedge clk);
    check("pdm_idle_code", heater_code, 0);
    count_ones(0, "pdm_ones_0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
